// File: rtl/button_switch_bus_reader.sv
// Bus read peripheral: syncs and debounces 4 buttons and 8 switches,
// latches press events, serves reads on a tristate bus, raises an IRQ.
//
// Ports:
//   CLK, RESET             clock, async active-high reset
//   BUS_ADDR, BUS_WE       bus address and write strobe
//   BUS_DATA               shared tristate data, driven only on read responses
//   BTN_IN, SW_IN          raw asynchronous buttons / switches
//   BUS_INTERRUPT_RAISE    level interrupt request
//   BUS_INTERRUPT_ACK      one-cycle acknowledge
module button_switch_bus_reader #(
  parameter logic [7:0] BASE_ADDR  = 8'hE0,
  parameter int         TICK_DIV   = 100000,
  parameter int         TICK_WIDTH = 17
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] BUS_ADDR,
  inout  wire  [7:0] BUS_DATA,
  input  logic       BUS_WE,
  input  logic [3:0] BTN_IN,
  input  logic [7:0] SW_IN,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);

  localparam int N = 12;

  // bits [7:0] switches, [11:8] buttons
  logic [N-1:0] raw;
  logic [N-1:0] s1_q;
  logic [N-1:0] s2_q;

  assign raw = {BTN_IN, SW_IN};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  end

  logic [TICK_WIDTH-1:0] cnt_q;
  logic                  tick;

  assign tick = (cnt_q == TICK_WIDTH'(TICK_DIV - 1));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  logic [3:0]   hist_q [N];
  logic [3:0]   hist_d [N];
  logic [N-1:0] deb_q;
  logic [N-1:0] deb_d;

  // the debounced value follows the freshly shifted history,
  // so it changes on the same edge the history becomes uniform
  always_comb begin
    for (int i = 0; i < N; i++) begin
      hist_d[i] = hist_q[i];
      deb_d[i]  = deb_q[i];
      if (tick) begin
        hist_d[i] = {hist_q[i][2:0], s2_q[i]};
      end
      if (hist_d[i] == 4'hF) begin
        deb_d[i] = 1'b1;
      end else if (hist_d[i] == 4'h0) begin
        deb_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < N; i++) begin
        hist_q[i] <= '0;
      end
      deb_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        hist_q[i] <= hist_d[i];
      end
      deb_q <= deb_d;
    end
  end

  logic [3:0] btn_rise;

  assign btn_rise = deb_d[11:8] & ~deb_q[11:8];

  logic       in_win;
  logic [1:0] off;
  logic       rd;
  logic       wr;

  assign in_win = (BUS_ADDR[7:2] == BASE_ADDR[7:2]);
  assign off    = BUS_ADDR[1:0];
  assign rd     = in_win & ~BUS_WE;
  assign wr     = in_win & BUS_WE;

  logic [3:0] evt_q;
  logic [3:0] evt_d;
  logic [3:0] evt_clr;
  logic [3:0] mask_q;
  logic [3:0] mask_d;
  logic       irq_new;
  logic       raise_d;
  logic [7:0] rd_mux;

  always_comb begin
    evt_clr = 4'h0;
    mask_d  = mask_q;
    if (rd && off == 2'd2) begin
      evt_clr = 4'hF;
    end
    if (wr && off == 2'd2) begin
      evt_clr = BUS_DATA[3:0];
    end
    if (wr && off == 2'd3) begin
      mask_d = BUS_DATA[3:0];
    end
    // new sets win over any clear on the same edge
    evt_d = (evt_q & ~evt_clr) | btn_rise;
  end

  // only a bit going 0->1 while unmasked may raise
  assign irq_new = |(btn_rise & ~evt_q & mask_q);

  always_comb begin
    raise_d = BUS_INTERRUPT_RAISE;
    if (irq_new) begin
      raise_d = 1'b1;
    end else if (BUS_INTERRUPT_ACK) begin
      raise_d = 1'b0;
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    unique case (off)
      2'd0: rd_mux = deb_q[7:0];
      2'd1: rd_mux = {4'h0, deb_q[11:8]};
      2'd2: rd_mux = {4'h0, evt_q};
      2'd3: rd_mux = {4'h0, mask_q};
      default: rd_mux = 8'h00;
    endcase
  end

  logic       rd_valid_q;
  logic [7:0] rd_data_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      evt_q               <= '0;
      mask_q              <= '0;
      BUS_INTERRUPT_RAISE <= 1'b0;
      rd_valid_q          <= 1'b0;
      rd_data_q           <= '0;
    end else begin
      evt_q               <= evt_d;
      mask_q              <= mask_d;
      BUS_INTERRUPT_RAISE <= raise_d;
      rd_valid_q          <= rd;
      rd_data_q           <= rd_mux;
    end
  end

  assign BUS_DATA = rd_valid_q ? rd_data_q : 8'hzz;

endmodule

// File: doc/button_switch_bus_reader.md
Name: button_switch_bus_reader

Overview:
- Read-side bus peripheral: synchronises and debounces 4 push-buttons and 8 slide switches.
- Latches button-press events and returns state, events and mask to the processor on bus reads by driving the shared tristate BUS_DATA.
- Raises an interrupt on unmasked press events. Counterpart to the write-only display peripherals on the same bus.

Parameters:
- BASE_ADDR, 8'hE0, base of a 4-byte register window (BASE_ADDR[1:0] must be 2'b00).
- TICK_DIV, 100000, CLK cycles per debounce sample tick (1 ms at 100 MHz); minimum 2.
- TICK_WIDTH, 17, prescaler counter width; must satisfy 2^TICK_WIDTH >= TICK_DIV.

Ports:
- CLK  in  1  system clock, 100 MHz.
- RESET  in  1  asynchronous, active-high reset.
- BUS_ADDR  in  8  bus address.
- BUS_DATA  inout  8  bus data; driven only during a read response, high-Z otherwise.
- BUS_WE  in  1  1 = write cycle, 0 = read cycle.
- BTN_IN  in  4  raw push-buttons, active-high, asynchronous.
- SW_IN  in  8  raw slide switches, asynchronous.
- BUS_INTERRUPT_RAISE  out  1  interrupt request, level.
- BUS_INTERRUPT_ACK  in  1  one-cycle acknowledge from processor.

Behaviour:
- Reset (async): all registers 0, all sync flops 0, BUS_DATA high-Z, BUS_INTERRUPT_RAISE=0, prescaler=0.
- Sync: every raw input passes through 2 flops before use.
- Prescaler: counts 0..TICK_DIV-1 and wraps; tick is a 1-cycle pulse on the wrap cycle.
- Debounce, per input:
  - On tick, shift the synced value into a 4-bit history.
  - When the history is all-1 or all-0 and differs from the debounced value, update the debounced value on the same edge.
  - Max latency after a stable change: 2 + 4*TICK_DIV cycles plus tick phase.
- Event: a 0->1 transition of debounced BTN[i] sets EVT[i], which is sticky.
- Register map, offset from BASE_ADDR:
  - +0 SW_STATE: read-only; writes ignored.
  - +1 BTN_STATE in bits[3:0]; bits[7:4]=0; read-only.
  - +2 EVT in [3:0]: read returns the value and clears it. Write of 1s clears the corresponding bits (write-1-to-clear).
  - +3 MASK in [3:0]: R/W, reset 0.
  - Unused upper bits read as 0.
- Read timing:
  - Addr in window with BUS_WE=0 sampled at edge N -> BUS_DATA driven with the value captured at edge N for exactly the cycle after N.
  - Back-to-back reads produce back-to-back responses.
  - Out-of-window address or BUS_WE=1 -> high-Z next cycle.
- Read-clear vs new event on the same edge: the read returns the old EVT; the new event bit remains set afterwards (set wins).
- Write-1-to-clear vs new event on the same bit, same edge: set wins.
- Interrupt:
  - RAISE goes 1 on the edge where any bit newly sets in (EVT & MASK).
  - RAISE holds until the edge sampling ACK=1, then goes 0.
  - A new masked event on the same edge as ACK keeps RAISE=1.
  - Pending-but-old events do not re-raise after ACK.
  - MASK changes alone never raise.
- RESET asserted mid-read: BUS_DATA goes high-Z immediately.

Test Plan:
- TICK_DIV=4: reset, then all reads return 0; BUS_DATA is Z outside responses; RAISE=0.
- SW_IN=8'hA5 held for 20 cycles, read E0 -> 8'hA5 on the cycle after the address.
- BTN_IN[2] bounces 1,0,1 each cycle, then is stable at 1 -> BTN_STATE=8'h04 only after 4 consecutive ticks; exactly one EVT bit 2.
- MASK=4'h4 via write E3=8'h04, press BTN[2] -> RAISE=1; hold ACK low 10 cycles, RAISE stays 1; ACK pulse -> RAISE=0 next edge.
- EVT=4'h4, read E2 on the same edge BTN[1] event fires -> returns 8'h04; following read returns 8'h02.
- Write E2=8'h0F with EVT=4'h3 -> EVT=0; write E0 ignored; read of E4 -> BUS_DATA stays Z.
